// File: rtl/signed_div.sv
// Sequential 16-bit signed divider: restoring unsigned core on magnitudes,
// sign correction in a final cycle, truncation toward zero.
module signed_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_sign_q, w_sign_q_nxt;
  logic           r_sign_r, w_sign_r_nxt;
  logic [W-1:0]   r_dvd, w_dvd_nxt;
  logic [W-1:0]   r_dvs, w_dvs_nxt;
  logic [W-1:0]   r_rem, w_rem_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [W-1:0]   r_in0, w_in0_nxt;
  logic           r_dbz_pend, w_dbz_pend_nxt;
  logic           r_ovf_pend, w_ovf_pend_nxt;
  logic [W-1:0]   r_quot, w_quot_nxt;
  logic [W-1:0]   r_remo, w_remo_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic           r_dbz, w_dbz_nxt;
  logic           r_ovf, w_ovf_nxt;

  // Shifted partial remainder and trial subtraction for one restoring step
  logic [W:0]     w_shift;
  logic           w_fits;
  logic [W-1:0]   w_sub;

  assign w_shift = {r_rem, r_dvd[W-1]};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[W-1:0] - r_dvs;

  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_in0      <= '0;
      r_dbz_pend <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_quot     <= '0;
      r_remo     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sign_q   <= w_sign_q_nxt;
      r_sign_r   <= w_sign_r_nxt;
      r_dvd      <= w_dvd_nxt;
      r_dvs      <= w_dvs_nxt;
      r_rem      <= w_rem_nxt;
      r_cnt      <= w_cnt_nxt;
      r_in0      <= w_in0_nxt;
      r_dbz_pend <= w_dbz_pend_nxt;
      r_ovf_pend <= w_ovf_pend_nxt;
      r_quot     <= w_quot_nxt;
      r_remo     <= w_remo_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_dbz      <= w_dbz_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sign_q_nxt   = r_sign_q;
    w_sign_r_nxt   = r_sign_r;
    w_dvd_nxt      = r_dvd;
    w_dvs_nxt      = r_dvs;
    w_rem_nxt      = r_rem;
    w_cnt_nxt      = r_cnt;
    w_in0_nxt      = r_in0;
    w_dbz_pend_nxt = r_dbz_pend;
    w_ovf_pend_nxt = r_ovf_pend;
    w_quot_nxt     = r_quot;
    w_remo_nxt     = r_remo;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_dbz_nxt      = r_dbz;
    w_ovf_nxt      = r_ovf;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sign_q_nxt   = in0[W-1] ^ in1[W-1];
          w_sign_r_nxt   = in0[W-1];
          // 0x8000 negates to itself, which is the correct unsigned magnitude
          w_dvd_nxt      = in0[W-1] ? (~in0 + W'(1)) : in0;
          w_dvs_nxt      = in1[W-1] ? (~in1 + W'(1)) : in1;
          w_rem_nxt      = '0;
          w_cnt_nxt      = CW'(W);
          w_in0_nxt      = in0;
          w_dbz_pend_nxt = (in1 == '0);
          w_ovf_pend_nxt = (in0 == 16'h8000) && (in1 == 16'hFFFF);
          w_busy_nxt     = 1'b1;
          w_state_nxt    = (in1 == '0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        w_rem_nxt = w_fits ? w_sub : w_shift[W-1:0];
        w_dvd_nxt = {r_dvd[W-2:0], w_fits};
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        if (r_dbz_pend) begin
          w_quot_nxt = 16'hFFFF;
          w_remo_nxt = r_in0;
          w_dbz_nxt  = 1'b1;
          w_ovf_nxt  = 1'b0;
        end else begin
          w_quot_nxt = r_sign_q ? (~r_dvd + W'(1)) : r_dvd;
          w_remo_nxt = r_sign_r ? (~r_rem + W'(1)) : r_rem;
          w_dbz_nxt  = 1'b0;
          w_ovf_nxt  = r_ovf_pend;
        end
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
